earom_ctrl: RTL
===============

Name: earom_ctrl

Overview:
- Device-side responder for the EAROM strobes from the 6502 subsystem address decode: address/data latch write (EA_ABOR), control write (EA_CONTROL) and data read (EA_READ).
- Emulates a 64x8 ER2055-style nonvolatile store with its latches, clock-edge command sequencing and program/erase busy timing.
- Sits between the decoder strobes, the CPU data bus and the high-score/options logic.

Parameters:
- DEPTH, 64, number of EAROM bytes; address width is log2(DEPTH) = 6.
- PROG_CYCLES, 1024, clk cycles a write or erase keeps the device busy; must be >= 2.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ea_abor_n  in  1  active-low address/data latch strobe, level for one CPU cycle.
- ea_control_n  in  1  active-low control latch strobe.
- ea_read_n  in  1  active-low read enable.
- ab  in  6  CPU address bits [5:0]; EAROM byte address.
- db_in  in  8  CPU write data.
- db_out  out  8  read data; valid while db_oe=1.
- db_oe  out  1  drive enable; equals ~ea_read_n, combinational.
- busy  out  1  write/erase in progress.

Behaviour:
- Strobes are two-flop synchronised; an action fires once, on the first clk after a falling edge of the synchronised strobe. A strobe held low fires once.
- ea_abor_n edge: addr_lat <= ab, data_lat <= db_in, sampled at that edge.
- ea_control_n edge: ctl_lat <= db_in[3:0] with bit0=CK, bit1=C2, bit2=C1, bit3=CS.
- A command executes only on a CK 0->1 transition between the old and new ctl_lat, with new CS=1. Mode {C1,C2}:
  - 00 read: out_lat <= mem[addr_lat] next cycle.
  - 10 write: mem[addr_lat] <= mem[addr_lat] | data_lat. Writes set bits only.
  - 01 erase: mem[addr_lat] <= 8'h00.
  - 11 standby: no action.
- No command executes when CS=0, on CK 1->1, or on CK 1->0.
- FSM states:
  - IDLE: accepts commands. Read stays in IDLE. Write/erase go to PROG.
  - PROG: counter runs from PROG_CYCLES-1 down to 0. The memory update happens on entry. At 0, return to IDLE and clear busy.
- During PROG:
  - Further CK edges are ignored; the command is dropped, not queued.
  - Latch writes are still accepted.
  - Reads return out_lat unchanged.
- db_out = out_lat regardless of busy. out_lat updates only on a read command.
- Reset values: addr_lat=0, data_lat=0, ctl_lat=0, out_lat=0, busy=0, FSM=IDLE, counter=0, db_out=0.
- The mem array is not reset (nonvolatile); see the optional feature.
- Reset mid-PROG: the programming operation aborts. The memory update has already taken effect at entry and is retained. busy=0.
- Simultaneous ea_abor_n and ea_control_n edges: both latches update in the same cycle. The command uses the old addr_lat/data_lat, and the new values are used from the next command.

Optional Feature:
- Macro: EAROM_CLEAR_ON_RESET_EN.
- Defined: after rst_n deasserts, a CLR state sweeps addresses 0..DEPTH-1, writing 8'h00 one per cycle. busy=1 for DEPTH cycles, then IDLE. CK edges are ignored during CLR; latch writes are accepted.
- Undefined: no CLR state; mem keeps its contents across reset and starts with simulator-undefined contents.

Decomposition:
- Package earom_pkg holds:
  - localparam EA_AW = 6;
  - enum state_t {IDLE, PROG, CLR};
  - enum mode_t {MODE_READ=2'b00, MODE_ERASE=2'b01, MODE_WRITE=2'b10, MODE_STBY=2'b11};
  - localparams for the ctl_lat bit indices.
- One sub-module, strobe_edge: 2-flop synchroniser plus falling-edge pulse. It is instantiated three times.

Test Plan:
- Reset then read: strobe ea_read_n low -> db_oe=1, db_out=8'h00, busy=0.
- Write/read back:
  - Erase address 6'h05.
  - Latch ab=6'h05, db_in=8'hA5.
  - Control 4'b1100 then 4'b1101 -> busy=1 for exactly PROG_CYCLES clks.
  - Latch 6'h05, control 4'b1000 then 4'b1001 -> db_out=8'hA5.
- OR semantics: write 8'h0F over stored 8'hA5 -> read 8'hAF. Erase then read -> 8'h00.
- Busy rejection:
  - Mid-PROG, issue a write to 6'h06 -> mem[6'h06] unchanged, busy drops on schedule.
  - Mid-PROG, issue a read -> db_out holds its previous value.
- Gating:
  - CS=0 with a CK rise -> no state change.
  - Write 4'b1101 twice (CK 1->1) -> single command, busy asserts once.
  - ea_abor_n held low for 10 clks -> one latch update.
- Reset mid-PROG:
  - rst_n low at count PROG_CYCLES/2 -> busy=0 immediately, written data retained.
  - With EAROM_CLEAR_ON_RESET_EN defined -> busy=1 for 64 clks, then all addresses read 8'h00.

Source files
------------

// File: rtl/earom_pkg.sv
// Shared types and constants for the EAROM (ER2055-style) emulation controller.
package earom_pkg;

    localparam int EA_AW = 6;

    localparam int CTL_CK = 0;
    localparam int CTL_C2 = 1;
    localparam int CTL_C1 = 2;
    localparam int CTL_CS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        CLR  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_ERASE = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_STBY  = 2'b11
    } mode_t;

endpackage

// File: rtl/earom_strobe_edge.sv
// Two-flop synchroniser for an active-low strobe plus a one-cycle pulse on its
// synchronised falling edge; a strobe held low produces a single pulse.
module strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= strobe_n;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall = sync3 & ~sync2;

endmodule

// File: rtl/earom_ctrl.sv
// EAROM responder: address/data/control latches, CK-edge command decode and
// program/erase busy timing. Define EAROM_CLEAR_ON_RESET_EN to sweep mem to 0 after reset.
//
// state | meaning
// IDLE  | accepting commands; reads complete here
// PROG  | write/erase busy, down-counter to terminal count 0
// CLR   | post-reset sweep writing 0 to every address
module earom_ctrl
    import earom_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int PROG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ea_abor_n,
    input  logic             ea_control_n,
    input  logic             ea_read_n,
    input  logic [EA_AW-1:0] ab,
    input  logic [7:0]       db_in,
    output logic [7:0]       db_out,
    output logic             db_oe,
    output logic             busy
);

    localparam int CW = $clog2((PROG_CYCLES > DEPTH) ? PROG_CYCLES : DEPTH);

    logic             abor_fall;
    logic             ctl_fall;
    logic             rd_fall_unused;
    logic [EA_AW-1:0] addr_lat;
    logic [7:0]       data_lat;
    logic [3:0]       ctl_lat;
    logic [7:0]       out_lat;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       mem [0:DEPTH-1];
    logic             mem_we;
    logic [EA_AW-1:0] mem_waddr;
    logic [7:0]       mem_wdata;
    logic             out_we;
    logic             cmd_fire;
    mode_t            mode;

    strobe_edge u_abor (.clk(clk), .rst_n(rst_n), .strobe_n(ea_abor_n),    .fall(abor_fall));
    strobe_edge u_ctl  (.clk(clk), .rst_n(rst_n), .strobe_n(ea_control_n), .fall(ctl_fall));
    // Read data comes straight from out_lat, so the read edge has no consumer.
    strobe_edge u_rd   (.clk(clk), .rst_n(rst_n), .strobe_n(ea_read_n),    .fall(rd_fall_unused));

    assign mode     = mode_t'({db_in[CTL_C1], db_in[CTL_C2]});
    assign cmd_fire = ctl_fall & ~ctl_lat[CTL_CK] & db_in[CTL_CK] & db_in[CTL_CS];

`ifdef EAROM_CLEAR_ON_RESET_EN
    logic clr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_done_q <= 1'b0;
        else if (state_q == CLR) clr_done_q <= 1'b1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr_lat;
        mem_wdata = 8'h00;
        out_we    = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef EAROM_CLEAR_ON_RESET_EN
                if (!clr_done_q) begin
                    state_d = CLR;
                    cnt_d   = CW'(DEPTH - 1);
                end else
`endif
                if (cmd_fire) begin
                    case (mode)
                        MODE_READ:  out_we = 1'b1;
                        MODE_WRITE: begin
                            mem_we    = 1'b1;
                            mem_wdata = mem[addr_lat] | data_lat;
                            state_d   = PROG;
                            cnt_d     = CW'(PROG_CYCLES - 1);
                        end
                        MODE_ERASE: begin
                            mem_we  = 1'b1;
                            state_d = PROG;
                            cnt_d   = CW'(PROG_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
            end
            PROG: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`ifdef EAROM_CLEAR_ON_RESET_EN
            CLR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[EA_AW-1:0];
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lat <= '0;
            data_lat <= '0;
            ctl_lat  <= '0;
            out_lat  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
        end else begin
            if (abor_fall) begin
                addr_lat <= ab;
                data_lat <= db_in;
            end
            if (ctl_fall) ctl_lat <= db_in[3:0];
            if (out_we)   out_lat <= mem[addr_lat];
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Nonvolatile store: never reset, so an aborted program keeps its entry-time update.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign busy   = (state_q != IDLE);
    assign db_oe  = ~ea_read_n;
    assign db_out = out_lat;

endmodule
